// File: rtl/ex_trigger_unit.sv
// ex_trigger_unit: multi-channel mcontrol debug triggers for the execute stage.
// Decodes the trigger CSRs 0x7A0 (tselect), 0x7A1 (tdata1), 0x7A2 (tdata2)
// and 0x7A4 (tinfo), and raises a same-cycle breakpoint request.
// Optional feature macro: ICOUNT_EN adds icount (type=3) support.
// Ports:
//   clk_i, rst_i          clock, async active-high reset
//   stall_i               hold: no hit/count/state update
//   csr_we_i/idx_i/wdata_i CSR write port; csr_sel_o/csr_rdata_o read side
//   mte_i, ex_valid_i     global trigger enable, EX instruction valid
//   pc_i, mem_addr_i      compare sources
//   is_load_i/is_store_i  EX access kind
//   retire_i              instruction retired (icount)
//   bkpt_o, bkpt_idx_o    breakpoint request and index of firing trigger
module ex_trigger_unit #(
    parameter int XLEN     = 32,
    parameter int NUM_TRIG = 4,
    parameter int TIDX_W   = (NUM_TRIG > 1) ? $clog2(NUM_TRIG) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              csr_we_i,
    input  logic [11:0]       csr_idx_i,
    input  logic [XLEN-1:0]   csr_wdata_i,
    output logic              csr_sel_o,
    output logic [XLEN-1:0]   csr_rdata_o,
    input  logic              mte_i,
    input  logic              ex_valid_i,
    input  logic [XLEN-1:0]   pc_i,
    input  logic [XLEN-1:0]   mem_addr_i,
    input  logic              is_load_i,
    input  logic              is_store_i,
    input  logic              retire_i,
    output logic              bkpt_o,
    output logic [TIDX_W-1:0] bkpt_idx_o
);

    localparam logic [11:0] CSR_TSEL  = 12'h7A0;
    localparam logic [11:0] CSR_TD1   = 12'h7A1;
    localparam logic [11:0] CSR_TD2   = 12'h7A2;
    localparam logic [11:0] CSR_TINFO = 12'h7A4;

    localparam logic [XLEN-1:0] TD1_RST = XLEN'(32'h2000_0000);
`ifdef ICOUNT_EN
    localparam logic [XLEN-1:0] TINFO = XLEN'(32'h0000_000C);
`else
    localparam logic [XLEN-1:0] TINFO = XLEN'(32'h0000_0004);
`endif

    // Legalise a tdata1 write: keep only implemented fields.
    function automatic logic [XLEN-1:0] f_legal(
        input logic [XLEN-1:0] w
    );
        logic [XLEN-1:0] r;
        r = '0;
        if (w[31:28] == 4'd2) begin
            r = w & XLEN'(32'h0010_0FC7);
            r[31:28] = 4'd2;
            if (!(w[10:7] == 4'd0 || w[10:7] == 4'd2 ||
                  w[10:7] == 4'd3))
                r[10:7] = 4'd0;
        end
`ifdef ICOUNT_EN
        else if (w[31:28] == 4'd3) begin
            r = w & XLEN'(32'h01FF_FE00);
            r[31:28] = 4'd3;
        end
`endif
        else begin
            r[31:28] = 4'hF;
        end
        return r;
    endfunction

    function automatic logic f_cmp(
        input logic [3:0]      mode,
        input logic [XLEN-1:0] a,
        input logic [XLEN-1:0] b
    );
        logic r;
        case (mode)
            4'd0:    r = (a == b);
            4'd2:    r = (a >= b);
            4'd3:    r = (a < b);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    logic [XLEN-1:0]     r_tdata1 [NUM_TRIG];
    logic [XLEN-1:0]     r_tdata2 [NUM_TRIG];
    logic [TIDX_W-1:0]   r_tsel;

    logic [NUM_TRIG-1:0] w_raw;
    logic [NUM_TRIG-1:0] w_chain;
    logic [NUM_TRIG-1:0] w_fend;
    logic [NUM_TRIG-1:0] w_memb;
    logic                w_fire_any;
    logic [TIDX_W-1:0]   w_fidx;
    logic                w_pfire;
    logic [TIDX_W-1:0]   w_pidx;
    logic                w_unused;

    assign w_unused = retire_i;

    // Per-trigger match and effective chain bit.
    always_comb begin
        w_raw   = '0;
        w_chain = '0;
        for (int i = 0; i < NUM_TRIG; i++) begin
            w_raw[i] = (r_tdata1[i][31:28] == 4'd2) &
                       mte_i & ex_valid_i & r_tdata1[i][6] &
                       ((r_tdata1[i][2] &
                         f_cmp(r_tdata1[i][10:7], pc_i,
                               r_tdata2[i])) |
                        (((r_tdata1[i][0] & is_load_i) |
                          (r_tdata1[i][1] & is_store_i)) &
                         f_cmp(r_tdata1[i][10:7], mem_addr_i,
                               r_tdata2[i])));
            w_chain[i] = (i < NUM_TRIG - 1) &&
                         (r_tdata1[i][31:28] == 4'd2) &&
                         r_tdata1[i][11];
        end
    end

    // Group resolution. A group ends at the first member with chain=0;
    // its fire is flagged at that (highest) index, then spread back
    // to every member for hit updates.
    always_comb begin
        logic acc;
        logic cur;
        acc    = 1'b1;
        cur    = 1'b0;
        w_fend = '0;
        w_memb = '0;
        for (int i = 0; i < NUM_TRIG; i++) begin
            acc = acc & w_raw[i];
            if (!w_chain[i]) begin
                w_fend[i] = acc;
                acc = 1'b1;
            end
        end
        for (int i = NUM_TRIG - 1; i >= 0; i--) begin
            if (!w_chain[i])
                cur = w_fend[i];
            w_memb[i] = cur;
        end
    end

    always_comb begin
        w_fidx = '0;
        for (int i = NUM_TRIG - 1; i >= 0; i--)
            if (w_fend[i])
                w_fidx = TIDX_W'(i);
    end

    assign w_fire_any = |w_fend;

`ifdef ICOUNT_EN
    logic [NUM_TRIG-1:0] r_pend;
    logic                w_pacc;

    always_comb begin
        w_pidx = '0;
        for (int i = NUM_TRIG - 1; i >= 0; i--)
            if (r_pend[i])
                w_pidx = TIDX_W'(i);
    end

    assign w_pfire = ex_valid_i & (|r_pend);
    // Pending icount only reports when no mcontrol group fires.
    assign w_pacc  = w_pfire & ~w_fire_any & ~stall_i;
`else
    assign w_pidx  = '0;
    assign w_pfire = 1'b0;
`endif

    assign bkpt_o     = w_fire_any | w_pfire;
    assign bkpt_idx_o = w_fire_any ? w_fidx :
                        (w_pfire ? w_pidx : '0);

    assign csr_sel_o = (csr_idx_i == CSR_TSEL) ||
                       (csr_idx_i == CSR_TD1)  ||
                       (csr_idx_i == CSR_TD2)  ||
                       (csr_idx_i == CSR_TINFO);

    always_comb begin
        csr_rdata_o = '0;
        case (csr_idx_i)
            CSR_TSEL:  csr_rdata_o = XLEN'(r_tsel);
            CSR_TD1:   csr_rdata_o = r_tdata1[r_tsel];
            CSR_TD2:   csr_rdata_o = r_tdata2[r_tsel];
            CSR_TINFO: csr_rdata_o = TINFO;
            default:   csr_rdata_o = '0;
        endcase
    end

    // CSR writes come last so they override hit/count updates.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_tsel <= '0;
            for (int i = 0; i < NUM_TRIG; i++) begin
                r_tdata1[i] <= TD1_RST;
                r_tdata2[i] <= '0;
            end
`ifdef ICOUNT_EN
            r_pend <= '0;
`endif
        end else if (!stall_i) begin
            for (int i = 0; i < NUM_TRIG; i++)
                if (w_memb[i])
                    r_tdata1[i][20] <= 1'b1;
`ifdef ICOUNT_EN
            for (int i = 0; i < NUM_TRIG; i++) begin
                if (r_tdata1[i][31:28] == 4'd3) begin
                    if (w_pacc && w_pidx == TIDX_W'(i)) begin
                        r_pend[i]       <= 1'b0;
                        r_tdata1[i][24] <= 1'b1;
                    end
                    if (retire_i && mte_i && r_tdata1[i][9] &&
                        r_tdata1[i][23:10] != 14'd0) begin
                        r_tdata1[i][23:10] <=
                            r_tdata1[i][23:10] - 14'd1;
                        if (r_tdata1[i][23:10] == 14'd1)
                            r_pend[i] <= 1'b1;
                    end
                end
            end
`endif
            if (csr_we_i) begin
                case (csr_idx_i)
                    CSR_TSEL: begin
                        if (csr_wdata_i < XLEN'(NUM_TRIG))
                            r_tsel <= csr_wdata_i[TIDX_W-1:0];
                    end
                    CSR_TD1: begin
                        r_tdata1[r_tsel] <= f_legal(csr_wdata_i);
`ifdef ICOUNT_EN
                        r_pend[r_tsel] <= 1'b0;
`endif
                    end
                    CSR_TD2: r_tdata2[r_tsel] <= csr_wdata_i;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ex_trigger_unit.sv
// Scoreboard bench for ex_trigger_unit: directed spec vectors plus
// randomized traffic against a field-level reference model.
`timescale 1ns/100ps
module tb_ex_trigger_unit;

    localparam int NT = 4;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        stall_i;
    logic        csr_we_i;
    logic [11:0] csr_idx_i;
    logic [31:0] csr_wdata_i;
    logic        csr_sel_o;
    logic [31:0] csr_rdata_o;
    logic        mte_i;
    logic        ex_valid_i;
    logic [31:0] pc_i;
    logic [31:0] mem_addr_i;
    logic        is_load_i;
    logic        is_store_i;
    logic        retire_i;
    logic        bkpt_o;
    logic [1:0]  bkpt_idx_o;

    always #5 clk = ~clk;

    ex_trigger_unit #(.XLEN(32), .NUM_TRIG(NT)) dut (
        .clk_i(clk), .rst_i(rst_i), .stall_i(stall_i),
        .csr_we_i(csr_we_i), .csr_idx_i(csr_idx_i),
        .csr_wdata_i(csr_wdata_i), .csr_sel_o(csr_sel_o),
        .csr_rdata_o(csr_rdata_o), .mte_i(mte_i),
        .ex_valid_i(ex_valid_i), .pc_i(pc_i),
        .mem_addr_i(mem_addr_i), .is_load_i(is_load_i),
        .is_store_i(is_store_i), .retire_i(retire_i),
        .bkpt_o(bkpt_o), .bkpt_idx_o(bkpt_idx_o)
    );

    typedef struct {
        bit          b;
        int          idx;
        bit          sel;
        logic [31:0] rd;
        string       nm;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_pass = 0;

    // Reference model state
    logic [31:0] m_t1 [NT];
    logic [31:0] m_t2 [NT];
    int          m_tsel;
    bit          m_pend [NT];

    function automatic void chk(string nm, logic [31:0] act,
                                logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk({e.nm, ".bkpt"}, 32'(bkpt_o), 32'(e.b));
            chk({e.nm, ".idx"}, 32'(bkpt_idx_o), 32'(e.idx));
            chk({e.nm, ".sel"}, 32'(csr_sel_o), 32'(e.sel));
            chk({e.nm, ".rdata"}, csr_rdata_o, e.rd);
        end
    end

    function automatic void m_reset();
        m_tsel = 0;
        for (int i = 0; i < NT; i++) begin
            m_t1[i] = 32'h2000_0000;
            m_t2[i] = 0;
            m_pend[i] = 0;
        end
    endfunction

    function automatic logic [31:0] m_legal(logic [31:0] w);
        logic [31:0] r;
        r = '0;
        case (w[31:28])
            4'd2: begin
                r[31:28] = 4'd2;
                r[20] = w[20];
                r[11] = w[11];
                r[6] = w[6];
                r[2:0] = w[2:0];
                if (w[10:7] inside {4'd0, 4'd2, 4'd3})
                    r[10:7] = w[10:7];
            end
`ifdef ICOUNT_EN
            4'd3: begin
                r[31:28] = 4'd3;
                r[24] = w[24];
                r[23:10] = w[23:10];
                r[9] = w[9];
            end
`endif
            default: r[31:28] = 4'hF;
        endcase
        return r;
    endfunction

    function automatic bit m_mc(int i);
        return m_t1[i][31:28] == 4'd2;
    endfunction

    function automatic bit m_chain(int i);
        return i < NT - 1 && m_mc(i) && m_t1[i][11];
    endfunction

    function automatic bit m_cmp(logic [3:0] md, logic [31:0] v,
                                 logic [31:0] r);
        if (md == 0) return v == r;
        if (md == 2) return v >= r;
        if (md == 3) return v < r;
        return 0;
    endfunction

    function automatic bit m_match(int i);
        logic [31:0] t;
        t = m_t1[i];
        if (!m_mc(i) || !mte_i || !ex_valid_i || !t[6]) return 0;
        if (t[2] && m_cmp(t[10:7], pc_i, m_t2[i])) return 1;
        if (((t[0] && is_load_i) || (t[1] && is_store_i)) &&
            m_cmp(t[10:7], mem_addr_i, m_t2[i]))
            return 1;
        return 0;
    endfunction

    function automatic int m_last(int i);
        int e;
        e = i;
        while (m_chain(e)) e++;
        return e;
    endfunction

    function automatic bit m_grp(int i);
        int s;
        s = i;
        while (s > 0 && m_chain(s - 1)) s--;
        for (int j = s; j <= m_last(i); j++)
            if (!m_match(j)) return 0;
        return 1;
    endfunction

    function automatic logic [31:0] m_read(logic [11:0] a);
        case (a)
            12'h7A0: return 32'(m_tsel);
            12'h7A1: return m_t1[m_tsel];
            12'h7A2: return m_t2[m_tsel];
`ifdef ICOUNT_EN
            12'h7A4: return 32'hC;
`else
            12'h7A4: return 32'h4;
`endif
            default: return 0;
        endcase
    endfunction

    // Issue one cycle: push the expectation (model or directed
    // constants), advance the model across the edge, then step.
    task automatic cycle(input bit ov, input bit eb = 0,
                         input int eidx = 0,
                         input logic [31:0] erd = 0,
                         input string nm = "rnd");
        exp_t e;
        bit   any, pany;
        int   best, pidx;
        bit   hit [NT];
        logic [13:0] c;
        any = 0; pany = 0; best = NT; pidx = 0;
        for (int i = 0; i < NT; i++) begin
            hit[i] = m_grp(i);
            if (hit[i]) begin
                any = 1;
                if (m_last(i) < best) best = m_last(i);
            end
        end
`ifdef ICOUNT_EN
        if (ex_valid_i)
            for (int i = NT - 1; i >= 0; i--)
                if (m_pend[i]) begin pany = 1; pidx = i; end
`endif
        e.nm  = nm;
        e.sel = csr_idx_i inside {12'h7A0, 12'h7A1, 12'h7A2, 12'h7A4};
        if (ov) begin
            e.b = eb; e.idx = eidx; e.rd = erd;
        end else begin
            e.b = any | pany;
            e.idx = any ? best : (pany ? pidx : 0);
            e.rd = m_read(csr_idx_i);
        end
        q.push_back(e);
        if (!stall_i) begin
            for (int i = 0; i < NT; i++)
                if (hit[i]) m_t1[i][20] = 1;
`ifdef ICOUNT_EN
            if (pany && !any) begin
                m_pend[pidx] = 0;
                m_t1[pidx][24] = 1;
            end
            for (int i = 0; i < NT; i++) begin
                c = m_t1[i][23:10];
                if (m_t1[i][31:28] == 3 && retire_i && mte_i &&
                    m_t1[i][9] && c != 0) begin
                    m_t1[i][23:10] = c - 1;
                    if (c == 1) m_pend[i] = 1;
                end
            end
`endif
            if (csr_we_i) begin
                if (csr_idx_i == 12'h7A0 && csr_wdata_i < NT)
                    m_tsel = int'(csr_wdata_i);
                if (csr_idx_i == 12'h7A1) begin
                    m_t1[m_tsel] = m_legal(csr_wdata_i);
                    m_pend[m_tsel] = 0;
                end
                if (csr_idx_i == 12'h7A2)
                    m_t2[m_tsel] = csr_wdata_i;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        csr_we_i = 0; ex_valid_i = 0; is_load_i = 0;
        is_store_i = 0; retire_i = 0; stall_i = 0;
        pc_i = 0; mem_addr_i = 0; csr_idx_i = 0; csr_wdata_i = 0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        idle();
        csr_we_i = 1; csr_idx_i = a; csr_wdata_i = d;
        cycle(0);
        csr_we_i = 0;
    endtask

    task automatic mem(input bit ld, input bit st,
                       input logic [31:0] ad);
        idle();
        ex_valid_i = 1; is_load_i = ld; is_store_i = st;
        mem_addr_i = ad;
    endtask

    function automatic logic [31:0] pick_val();
        int k;
        k = $urandom % 4;
        if (k == 0) return $urandom;
        return m_t2[$urandom % NT] + 32'($urandom % 9) - 32'd4;
    endfunction

    function automatic logic [11:0] pick_csr();
        case ($urandom % 6)
            0: return 12'h7A0;
            1: return 12'h7A1;
            2: return 12'h7A1;
            3: return 12'h7A2;
            4: return 12'h7A4;
            default: return 12'h7A3;
        endcase
    endfunction

    function automatic logic [31:0] pick_td1();
        logic [31:0] w;
        int t;
        w = $urandom;
        t = $urandom % 5;
        w[31:28] = (t < 3) ? 4'd2 : ((t == 3) ? 4'd3 : 4'd5);
        w[6] = ($urandom % 4) != 0;
        w[9] = ($urandom % 4) != 0;
        if (t == 3) w[23:10] = 14'($urandom % 5);
        if (t < 3 && ($urandom % 3) != 0)
            case ($urandom % 3)
                0: w[10:7] = 4'd0;
                1: w[10:7] = 4'd2;
                default: w[10:7] = 4'd3;
            endcase
        return w;
    endfunction

    initial begin
        idle();
        mte_i = 1;
        rst_i = 1;
        m_reset();
        repeat (2) @(posedge clk);
        #1 rst_i = 0;

        // Reset state
        csr_idx_i = 12'h7A1; cycle(1, 0, 0, 32'h2000_0000, "rst_td1");
        csr_idx_i = 12'h7A0; cycle(1, 0, 0, 32'h0, "rst_tsel");
        csr_idx_i = 12'h7A4; cycle(0, 0, 0, 0, "tinfo");

        // Execute eq on trigger 1
        wr(12'h7A0, 1);
        wr(12'h7A2, 32'h8000_0100);
        wr(12'h7A1, 32'h2000_0044);
        idle(); ex_valid_i = 1; pc_i = 32'h8000_0100;
        csr_idx_i = 12'h7A1;
        cycle(1, 1, 1, 32'h2000_0044, "exec_eq");
        idle(); csr_idx_i = 12'h7A1;
        cycle(1, 0, 0, 32'h2010_0044, "exec_hit");

        // Load ge on trigger 2
        wr(12'h7A0, 2);
        wr(12'h7A1, 32'h2000_0141);
        wr(12'h7A2, 32'h1000);
        mem(1, 0, 32'h0FFC); cycle(1, 0, 0, 0, "ld_ge_below");
        mem(1, 0, 32'h1000); cycle(1, 1, 2, 0, "ld_ge_eq");
        mem(0, 1, 32'h1000); cycle(1, 0, 0, 0, "st_no_ld");

        // Chain t0 (store ge 0x2000) -> t1 (store lt 0x2100)
        wr(12'h7A0, 0);
        wr(12'h7A1, 32'h2000_0942);
        wr(12'h7A2, 32'h2000);
        wr(12'h7A0, 1);
        wr(12'h7A1, 32'h2000_01C2);
        wr(12'h7A2, 32'h2100);
        mem(0, 1, 32'h2080); cycle(1, 1, 1, 0, "chain_fire");
        idle(); csr_idx_i = 12'h7A1;
        cycle(1, 0, 0, 32'h2010_01C2, "chain_hit1");
        wr(12'h7A0, 0);
        idle(); csr_idx_i = 12'h7A1;
        cycle(1, 0, 0, 32'h2010_0942, "chain_hit0");
        mem(0, 1, 32'h2200); cycle(1, 0, 0, 0, "chain_miss");

        // WARL tselect and priority
        wr(12'h7A0, 7);
        idle(); csr_idx_i = 12'h7A0;
        cycle(1, 0, 0, 32'h0, "tsel_warl");
        wr(12'h7A1, 32'h2000_0041);
        wr(12'h7A2, 32'h3000);
        mem(1, 0, 32'h3000); stall_i = 1;
        cycle(1, 1, 0, 0, "prio_stall");
        idle(); csr_idx_i = 12'h7A1;
        cycle(1, 0, 0, 32'h2000_0041, "stall_nohit");
        mem(1, 0, 32'h3000); cycle(1, 1, 0, 0, "prio");
        idle(); csr_idx_i = 12'h7A1;
        cycle(1, 0, 0, 32'h2010_0041, "prio_hit");

        // icount
        wr(12'h7A0, 3);
        wr(12'h7A1, 32'h3000_0E00);
`ifdef ICOUNT_EN
        idle(); retire_i = 1; cycle(0);
        idle(); retire_i = 1; stall_i = 1; cycle(0);
        idle(); retire_i = 1; cycle(0);
        idle(); retire_i = 1; cycle(0);
        idle(); ex_valid_i = 1;
        cycle(1, 1, 3, 0, "icount_fire");
        idle(); csr_idx_i = 12'h7A1;
        cycle(1, 0, 0, 32'h3100_0200, "icount_hit");
`else
        idle(); csr_idx_i = 12'h7A1;
        cycle(1, 0, 0, 32'hF000_0000, "type3_unsup");
`endif

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            idle();
            mte_i      = ($urandom % 8) != 0;
            ex_valid_i = ($urandom % 4) != 0;
            is_load_i  = ($urandom % 3) == 0;
            is_store_i = !is_load_i && ($urandom % 2);
            retire_i   = $urandom % 2;
            stall_i    = ($urandom % 8) == 0;
            pc_i       = pick_val();
            mem_addr_i = pick_val();
            csr_idx_i  = pick_csr();
            if (($urandom % 5) == 0) begin
                csr_we_i = 1;
                case (csr_idx_i)
                    12'h7A0: csr_wdata_i = $urandom % 6;
                    12'h7A1: csr_wdata_i = pick_td1();
                    default: csr_wdata_i = pick_val();
                endcase
            end
            cycle(0);
        end

        // Asynchronous reset in the middle of a cycle
        mte_i = 1;
        wr(12'h7A0, 1);
        wr(12'h7A1, 32'h2000_0044);
        wr(12'h7A2, 32'h8000_0100);
        idle(); ex_valid_i = 1; pc_i = 32'h8000_0100;
        csr_idx_i = 12'h7A1;
        #1 rst_i = 1;
        #1;
        chk("arst.bkpt", 32'(bkpt_o), 32'h0);
        chk("arst.idx", 32'(bkpt_idx_o), 32'h0);
        chk("arst.td1", csr_rdata_o, 32'h2000_0000);
        csr_idx_i = 12'h7A0;
        #1;
        chk("arst.tsel", csr_rdata_o, 32'h0);
        m_reset();
        @(negedge clk);
        #1 rst_i = 0;
        @(posedge clk);
        #1;
        idle(); csr_idx_i = 12'h7A1;
        cycle(1, 0, 0, 32'h2000_0000, "post_rst");
        idle();
        @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
